// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for the R10K rename stage.
// Optional FREE_LIST_BYPASS_EN forwards a freed tag straight to alloc_tag while empty.
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

package free_list_pkg;
   localparam int TAG_W = $clog2(`PHYS_REG_SZ);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             valid;
      logic             ready;
   } phys_tag_t;
endpackage

module free_list
   import free_list_pkg::*;
#(
   parameter int PHYS_REG_SZ = `PHYS_REG_SZ,
   parameter int ARCH_REG_SZ = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         alloc_en,
   output phys_tag_t                    alloc_tag,
   input  logic                         free_en,
   input  phys_tag_t                    free_tag,
   input  logic                         retire_en,
   input  logic                         squash,
   output logic                         empty,
   output logic [$clog2(PHYS_REG_SZ):0] free_count,
   output logic                         error
);

   localparam int IDX_W = $clog2(PHYS_REG_SZ);
   localparam int PTR_W = IDX_W + 1;
   localparam int FREE_AT_RESET = PHYS_REG_SZ - ARCH_REG_SZ;
   localparam logic [PTR_W-1:0] FULL_CNT   = PTR_W'(PHYS_REG_SZ);
   localparam logic [PTR_W-1:0] RESET_TAIL = PTR_W'(FREE_AT_RESET);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   logic [TAG_W-1:0] entries [PHYS_REG_SZ];
   logic [PTR_W-1:0] head, tail, rhead;
   logic [PTR_W-1:0] rhead_next;
   logic             bypass;
   logic             do_alloc, do_free, retire_ok;
   logic             alloc_err, free_err, retire_err;
   logic             unused_ready;

   assign unused_ready = free_tag.ready;

   // Pointers carry a wrap bit, so the difference is the occupancy even across wrap.
   assign free_count = tail - head;
   assign empty      = (free_count == '0);

`ifdef FREE_LIST_BYPASS_EN
   assign bypass = empty & free_en & free_tag.valid & alloc_en & ~squash;
`else
   assign bypass = 1'b0;
`endif

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      do_alloc   = 1'b0;
      alloc_err  = 1'b0;
      do_free    = 1'b0;
      free_err   = 1'b0;
      retire_ok  = 1'b0;
      retire_err = 1'b0;
      rhead_next = rhead;

      // Dispatch is squashed away in a recovery cycle, so alloc is ignored then.
      if (alloc_en && !squash) begin
         do_alloc  = ~empty;
         alloc_err = empty & ~bypass;
      end

      if (free_en && free_tag.valid && !bypass) begin
         do_free  = (free_count < FULL_CNT);
         free_err = (free_count == FULL_CNT);
      end

      // The retire head may only walk over tags that dispatch has already handed out.
      if (retire_en) begin
         retire_ok  = (rhead != head);
         retire_err = (rhead == head);
      end
      if (retire_ok)
         rhead_next = rhead + PTR_ONE;

      alloc_tag.tag   = bypass ? free_tag.tag : entries[head[IDX_W-1:0]];
      alloc_tag.valid = bypass | ~empty;
      alloc_tag.ready = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         rhead <= '0;
         tail  <= RESET_TAIL;
         error <= 1'b0;
         // NOTE: the tag store is reset because its contents define the post-reset free set.
         for (int i = 0; i < PHYS_REG_SZ; i++)
            entries[i] <= (i < FREE_AT_RESET) ? TAG_W'(ARCH_REG_SZ + i) : '0;
      end else begin
         if (do_free) begin
            entries[tail[IDX_W-1:0]] <= free_tag.tag;
            tail                     <= tail + PTR_ONE;
         end

         // Retire takes effect before squash, so recovery lands on the updated retire head.
         if (squash)
            head <= rhead_next;
         else if (do_alloc)
            head <= head + PTR_ONE;

         rhead <= rhead_next;

         if (alloc_err || free_err || retire_err)
            error <= 1'b1;
      end
   end

endmodule
